// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// Defaults describe 640x480@60 Hz on a 25.175 MHz pixel clock.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1024;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis (horizontal or vertical): wrapping counter plus registered
// sync/active/wrap qualifiers computed from the next count so they match count.
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE   = 640,
    parameter int FP       = 16,
    parameter int SYNC     = 96,
    parameter int BP       = 48,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output logic               sync,
    output logic               active,
    output logic               wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [COORD_W:0] LAST_W       = (COORD_W+1)'(TOTAL - 1);
    localparam logic [COORD_W:0] ACTIVE_W     = (COORD_W+1)'(ACTIVE);
    localparam logic [COORD_W:0] SYNC_START_W = (COORD_W+1)'(ACTIVE + FP);
    localparam logic [COORD_W:0] SYNC_END_W   = (COORD_W+1)'(ACTIVE + FP + SYNC);

    if (TOTAL > MAX_TOTAL) begin : g_total_too_large
        $error("timing_axis: total period exceeds the 10-bit coordinate range");
    end

    logic [COORD_W-1:0] count_r;
    logic [COORD_W-1:0] count_next_s;
    logic [COORD_W:0]   count_next_ext_s;
    logic               sync_r;
    logic               active_r;
    logic               wrap_r;

    // Next counter value: hold, increment, or wrap at the last position.
    always_comb begin
        count_next_s = count_r;
        if (step == 1'b1) begin
            if (wrap_r == 1'b1) begin
                count_next_s = '0;
            end else begin
                count_next_s = count_r + {{(COORD_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_next_s = count_r;
        end
        count_next_ext_s = {1'b0, count_next_s};
    end

    // Counter and qualifier registers, all derived from the next count.
    always_ff @(posedge clk) begin
        if (reset == 1'b1) begin
            count_r  <= '0;
            sync_r   <= ~SYNC_POL;
            active_r <= 1'b1;
            wrap_r   <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            sync_r   <= ((count_next_ext_s >= SYNC_START_W) && (count_next_ext_s < SYNC_END_W))
                        ? SYNC_POL : ~SYNC_POL;
            active_r <= (count_next_ext_s < ACTIVE_W);
            wrap_r   <= (count_next_ext_s == LAST_W);
        end
    end

    assign count  = count_r;
    assign sync   = sync_r;
    assign active = active_r;
    assign wrap   = wrap_r;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: raw x/y counters with zero-latency sync,
// display and frame-start qualifiers, plus a free-running frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [COORD_W:0] H_ACT_W = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] V_ACT_W = (COORD_W+1)'(V_ACTIVE);

    if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_total_too_large
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end

    logic       h_active_s;
    logic       h_wrap_s;
    logic       v_active_s;
    logic       v_wrap_s;
    logic       v_step_s;
    logic       h_act_next_s;
    logic       v_act_next_s;
    logic       display_on_r;
    logic       frame_start_r;
    logic [7:0] frame_count_r;

    assign v_step_s = pix_en & h_wrap_s;

    timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk(clk), .reset(reset), .step(pix_en),
        .count(x), .sync(hsync), .active(h_active_s), .wrap(h_wrap_s)
    );

    timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk(clk), .reset(reset), .step(v_step_s),
        .count(y), .sync(vsync), .active(v_active_s), .wrap(v_wrap_s)
    );

    // Active-region flags of the coming cycle, so display_on lines up with x/y.
    always_comb begin
        h_act_next_s = h_active_s;
        v_act_next_s = v_active_s;
        if (pix_en == 1'b1) begin
            h_act_next_s = h_wrap_s | (({1'b0, x} + 11'd1) < H_ACT_W);
        end else begin
            h_act_next_s = h_active_s;
        end
        if (v_step_s == 1'b1) begin
            v_act_next_s = v_wrap_s | (({1'b0, y} + 11'd1) < V_ACT_W);
        end else begin
            v_act_next_s = v_active_s;
        end
    end

    // Frame-level registers: display window, origin pulse and frame counter.
    always_ff @(posedge clk) begin
        if (reset == 1'b1) begin
            display_on_r  <= 1'b1;
            frame_start_r <= 1'b1;
            frame_count_r <= 8'd0;
        end else begin
            display_on_r <= h_act_next_s & v_act_next_s;
            if (pix_en == 1'b1) begin
                frame_start_r <= h_wrap_s & v_wrap_s;
            end else begin
                frame_start_r <= frame_start_r;
            end
            if ((v_step_s & v_wrap_s) == 1'b1) begin
                frame_count_r <= frame_count_r + 8'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign display_on  = display_on_r;
    assign frame_start = frame_start_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default-timing instance and a shrunken-timing instance
// share stimulus; expected raster state is derived from enabled-step counts.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct packed {
        obs_t d;
        obs_t s;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b1;

    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_hs, d_vs, d_de, d_fs, s_hs, s_vs, s_de, s_fs;
    logic [7:0] d_fc, s_fc;

    int n_cmp = 0;
    int n_err = 0;
    int n_def = 0;
    int n_sm  = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    vga_timing_gen dut_def (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .frame_start(d_fs), .frame_count(d_fc)
    );

    // Small raster: 16 x 12 total, active-high sync.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1)
    ) dut_sm (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .frame_start(s_fs), .frame_count(s_fc)
    );

    function automatic obs_t model(input int n, input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb, input bit pol);
        obs_t o;
        int ht, vt, xx, line, yy;
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        xx   = n % ht;
        line = n / ht;
        yy   = line % vt;
        o.x  = 10'(xx);
        o.y  = 10'(yy);
        o.hs = (xx >= ha + hf && xx < ha + hf + hsw) ? pol : !pol;
        o.vs = (yy >= va + vf && yy < va + vf + vsw) ? pol : !pol;
        o.de = (xx < ha) && (yy < va);
        o.fs = (xx == 0) && (yy == 0);
        o.fc = 8'((line / vt) % 256);
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic compare_all(input string inst, input obs_t got, input obs_t e);
        check_eq({inst, ".x"},           32'(got.x),  32'(e.x));
        check_eq({inst, ".y"},           32'(got.y),  32'(e.y));
        check_eq({inst, ".hsync"},       32'(got.hs), 32'(e.hs));
        check_eq({inst, ".vsync"},       32'(got.vs), 32'(e.vs));
        check_eq({inst, ".display_on"},  32'(got.de), 32'(e.de));
        check_eq({inst, ".frame_start"}, 32'(got.fs), 32'(e.fs));
        check_eq({inst, ".frame_count"}, 32'(got.fc), 32'(e.fc));
    endtask

    // Drive one cycle, push the expected post-edge state, then pop and compare.
    task automatic cycle(input logic rst, input logic en);
        exp_t e;
        obs_t gd, gs;
        reset  = rst;
        pix_en = en;
        if (rst) begin
            n_def = 0;
            n_sm  = 0;
        end else if (en) begin
            n_def++;
            n_sm++;
        end
        e.d = model(n_def, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        e.s = model(n_sm, 8, 2, 3, 3, 6, 2, 2, 2, 1'b1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e  = sb_q.pop_front();
        gd = '{d_x, d_y, d_hs, d_vs, d_de, d_fs, d_fc};
        gs = '{s_x, s_y, s_hs, s_vs, s_de, s_fs, s_fc};
        compare_all("def", gd, e.d);
        compare_all("sm", gs, e.s);
    endtask

    initial begin
        // Reset held three cycles, then free running through the first lines.
        repeat (3) cycle(1'b1, 1'b1);
        repeat (5 * 192 + 3 * 16 + 5) cycle(1'b0, 1'b1);
        // Mid-frame reset with the small raster at frame 5.
        cycle(1'b1, 1'b1);
        // Clock enable toggling around the end of a default line.
        repeat (798) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (2000) cycle(1'b0, ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0);
        // Enough whole frames to carry the small frame counter through 255 -> 0.
        repeat (257 * 192 + 50) cycle(1'b0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
